// File: rtl/oscillator_types_pkg.sv
// Shared types for the oscillator cores and the divider arbiter that serves them.
package oscillator_types_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE_E    = 1'b0,
    ARB_FORWARD_E = 1'b1
  } osc_arb_state_t;

  // Width of an index into n requesters; never collapses below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_div_arbiter_if.sv
// Requester-side and divider-side AXI-stream bundle of the divider arbiter.
interface osc_div_arbiter_if #(
  parameter int NR_OF_REQUESTERS_P = 4,
  parameter int AXI_DATA_WIDTH_P   = 32,
  parameter int AXI_ID_WIDTH_P     = 3
);

  logic [NR_OF_REQUESTERS_P-1:0]                       req_tvalid;
  logic [NR_OF_REQUESTERS_P-1:0]                       req_tready;
  logic [NR_OF_REQUESTERS_P-1:0][AXI_DATA_WIDTH_P-1:0] req_tdata;
  logic [NR_OF_REQUESTERS_P-1:0]                       req_tlast;

  logic [NR_OF_REQUESTERS_P-1:0] rsp_tvalid;
  logic [NR_OF_REQUESTERS_P-1:0] rsp_tready;
  logic [AXI_DATA_WIDTH_P-1:0]   rsp_tdata;
  logic                          rsp_tlast;
  logic                          rsp_tuser;

  logic                        div_egr_tvalid;
  logic                        div_egr_tready;
  logic [AXI_DATA_WIDTH_P-1:0] div_egr_tdata;
  logic                        div_egr_tlast;
  logic [AXI_ID_WIDTH_P-1:0]   div_egr_tid;

  logic                        div_ing_tvalid;
  logic                        div_ing_tready;
  logic [AXI_DATA_WIDTH_P-1:0] div_ing_tdata;
  logic                        div_ing_tlast;
  logic [AXI_ID_WIDTH_P-1:0]   div_ing_tid;
  logic                        div_ing_tuser;

  // Arbiter view.
  modport slave (
    input  req_tvalid, req_tdata, req_tlast,
    output req_tready,
    output rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tuser,
    input  rsp_tready,
    output div_egr_tvalid, div_egr_tdata, div_egr_tlast, div_egr_tid,
    input  div_egr_tready,
    input  div_ing_tvalid, div_ing_tdata, div_ing_tlast, div_ing_tid, div_ing_tuser,
    output div_ing_tready
  );

  // Environment view: oscillator cores plus the divider core.
  modport master (
    output req_tvalid, req_tdata, req_tlast,
    input  req_tready,
    input  rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tuser,
    output rsp_tready,
    input  div_egr_tvalid, div_egr_tdata, div_egr_tlast, div_egr_tid,
    output div_egr_tready,
    output div_ing_tvalid, div_ing_tdata, div_ing_tlast, div_ing_tid, div_ing_tuser,
    input  div_ing_tready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin priority encoder: the first eligible index at or
// after rr_ptr (wrapping) wins.
module rr_arbiter
  import oscillator_types_pkg::*;
#(
  parameter  int NR_OF_REQUESTERS_P = 4,
  localparam int IDX_W              = idx_w(NR_OF_REQUESTERS_P)
) (
  input  logic [NR_OF_REQUESTERS_P-1:0] eligible,
  input  logic [IDX_W-1:0]              rr_ptr,
  output logic [IDX_W-1:0]              winner_id,
  output logic                          winner_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to rr_ptr so the nearest eligible index is kept.
  always_comb begin
    winner_valid = 1'b0;
    winner_id    = '0;
    cand         = '0;
    for (int k = NR_OF_REQUESTERS_P - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NR_OF_REQUESTERS_P);
      if (eligible[cand]) begin
        winner_valid = 1'b1;
        winner_id    = cand;
      end
    end
  end

endmodule

// File: rtl/osc_div_arbiter.sv
// Shares one long-division core between several oscillator cores: round-robin packet
// egress tagged with the requester index, tid-routed quotient return, one division in flight each.
module osc_div_arbiter
  import oscillator_types_pkg::*;
#(
  parameter int NR_OF_REQUESTERS_P = 4,
  parameter int AXI_DATA_WIDTH_P   = 32,
  parameter int AXI_ID_WIDTH_P     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  osc_div_arbiter_if.slave              bus,
  output logic [NR_OF_REQUESTERS_P-1:0] sr_pending,
  output logic                          sr_bad_tid
);

  localparam int                  N        = NR_OF_REQUESTERS_P;
  localparam int                  IW       = AXI_ID_WIDTH_P;
  localparam int                  IDX_W    = idx_w(N);
  localparam logic [IW:0]         N_EXT    = (IW + 1)'(N);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);

  osc_arb_state_t              state_q;
  osc_arb_state_t              state_d;
  logic [IDX_W-1:0]            grant_id;
  logic [IDX_W-1:0]            rr_ptr;
  logic [N-1:0]                eligible;
  logic [IDX_W-1:0]            winner_id;
  logic                        winner_valid;
  logic                        grant_load;
  logic                        egr_done;
  logic [AXI_DATA_WIDTH_P-1:0] egr_data;
  logic [N-1:0]                pending_d;
  logic [IDX_W-1:0]            ing_idx;
  logic                        tid_ok;
  logic                        ing_last_hs;
  logic                        ing_bad;

  // A requester with a division in flight is invisible to the arbiter.
  assign eligible = bus.req_tvalid & ~sr_pending;

  rr_arbiter #(
    .NR_OF_REQUESTERS_P (N)
  ) u_rr_arbiter (
    .eligible     (eligible),
    .rr_ptr       (rr_ptr),
    .winner_id    (winner_id),
    .winner_valid (winner_valid)
  );

  always_comb begin
    state_d            = state_q;
    grant_load         = 1'b0;
    egr_done           = 1'b0;
    bus.req_tready     = '0;
    bus.div_egr_tvalid = 1'b0;
    bus.div_egr_tlast  = 1'b0;
    bus.div_egr_tid    = '0;
    egr_data           = '0;
    case (state_q)
      ARB_IDLE_E: begin
        if (winner_valid) begin
          grant_load = 1'b1;
          state_d    = ARB_FORWARD_E;
        end
      end
      ARB_FORWARD_E: begin
        bus.div_egr_tvalid     = bus.req_tvalid[grant_id];
        egr_data               = bus.req_tdata[grant_id];
        bus.div_egr_tlast      = bus.req_tlast[grant_id];
        bus.div_egr_tid        = IW'(grant_id);
        bus.req_tready[grant_id] = bus.div_egr_tready;
        if (bus.req_tvalid[grant_id] && bus.div_egr_tready && bus.req_tlast[grant_id]) begin
          egr_done = 1'b1;
          state_d  = ARB_IDLE_E;
        end
      end
      default: state_d = ARB_IDLE_E;
    endcase
  end

  assign bus.div_egr_tdata = egr_data;

  // Ingress demux is purely combinational; out-of-range tids are swallowed.
  always_comb begin
    ing_idx            = IDX_W'(bus.div_ing_tid);
    tid_ok             = ({1'b0, bus.div_ing_tid} < N_EXT);
    bus.rsp_tvalid     = '0;
    bus.div_ing_tready = 1'b1;
    if (tid_ok) begin
      bus.rsp_tvalid[ing_idx] = bus.div_ing_tvalid;
      bus.div_ing_tready      = bus.rsp_tready[ing_idx];
    end
  end

  assign bus.rsp_tdata = bus.div_ing_tdata;
  assign bus.rsp_tlast = bus.div_ing_tlast;
  assign bus.rsp_tuser = bus.div_ing_tuser;

  assign ing_last_hs = bus.div_ing_tvalid & bus.div_ing_tready & bus.div_ing_tlast;
  assign ing_bad     = ing_last_hs & ~tid_ok;

  // Set and clear touch different requesters, since a pending one is never granted.
  always_comb begin
    pending_d = sr_pending;
    if (egr_done) begin
      pending_d[grant_id] = 1'b1;
    end
    if (ing_last_hs && tid_ok) begin
      pending_d[ing_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE_E;
      grant_id   <= '0;
      rr_ptr     <= '0;
      sr_pending <= '0;
      sr_bad_tid <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_pending <= pending_d;
      sr_bad_tid <= ing_bad;
      if (grant_load) begin
        grant_id <= winner_id;
        rr_ptr   <= (winner_id == LAST_IDX) ? '0 : winner_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osc_div_arbiter.sv
// Directed bench for osc_div_arbiter with N=4: egress and response beats are checked
// against scoreboard queues filled as stimulus is issued.
module tb_osc_div_arbiter;
  import oscillator_types_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sr_pending;
  logic         sr_bad_tid;

  osc_div_arbiter_if #(
    .NR_OF_REQUESTERS_P (N),
    .AXI_DATA_WIDTH_P   (DW),
    .AXI_ID_WIDTH_P     (IW)
  ) bus ();

  osc_div_arbiter #(
    .NR_OF_REQUESTERS_P (N),
    .AXI_DATA_WIDTH_P   (DW),
    .AXI_ID_WIDTH_P     (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sr_pending (sr_pending),
    .sr_bad_tid (sr_bad_tid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] src_q [N][$];   // per requester: {last, data}
  logic [35:0] exp_egr[$];     // {tid, last, data}
  logic [36:0] ing_q[$];       // {tid, user, last, data}
  logic [37:0] exp_rsp[$];     // {onehot, user, last, data}

  logic         rst_nx     = 1'b1;
  logic         egr_rdy_nx = 1'b1;
  logic [N-1:0] rsp_rdy_nx = '1;
  bit           auto_rsp   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rsp(input logic [IW-1:0] tid, input logic [DW-1:0] d, input logic u);
    ing_q.push_back({tid, u, 1'b1, d});
    if (tid < 3'd4) exp_rsp.push_back({4'b0001 << tid, u, 1'b1, d});
  endtask

  task automatic exp_beat(input int r, input logic last, input logic [DW-1:0] d);
    exp_egr.push_back({IW'(r), last, d});
  endtask

  task automatic push_pkt(input int r, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                          input int n_exp);
    src_q[r].push_back({1'b0, dvd});
    src_q[r].push_back({1'b1, dvs});
    if (n_exp > 0) exp_beat(r, 1'b0, dvd);
    if (n_exp > 1) exp_beat(r, 1'b1, dvs);
  endtask

  // Drive just after the rising edge, observe handshakes on the falling edge.
  task automatic tick();
    logic [N-1:0]  rhs;
    logic [35:0]   e;
    logic [37:0]   er;
    @(posedge clk);
    #1;
    rst = rst_nx;
    bus.div_egr_tready = egr_rdy_nx;
    bus.rsp_tready = rsp_rdy_nx;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        bus.req_tvalid[i] = 1'b1;
        bus.req_tlast[i]  = src_q[i][0][32];
        bus.req_tdata[i]  = src_q[i][0][31:0];
      end else begin
        bus.req_tvalid[i] = 1'b0;
        bus.req_tlast[i]  = 1'b0;
        bus.req_tdata[i]  = '0;
      end
    end
    if (ing_q.size() != 0) begin
      bus.div_ing_tvalid = 1'b1;
      {bus.div_ing_tid, bus.div_ing_tuser, bus.div_ing_tlast, bus.div_ing_tdata} = ing_q[0];
    end else begin
      bus.div_ing_tvalid = 1'b0;
      {bus.div_ing_tid, bus.div_ing_tuser, bus.div_ing_tlast, bus.div_ing_tdata} = '0;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.req_tvalid[i] && bus.req_tready[i]) void'(src_q[i].pop_front());
    end
    if (bus.div_egr_tvalid && bus.div_egr_tready) begin
      if (exp_egr.size() == 0) begin
        chk("egr_extra_beat", {bus.div_egr_tid, bus.div_egr_tlast, bus.div_egr_tdata}, 64'hDEAD);
      end else begin
        e = exp_egr.pop_front();
        chk("egr_beat", {bus.div_egr_tid, bus.div_egr_tlast, bus.div_egr_tdata}, e);
      end
      if (auto_rsp && bus.div_egr_tlast)
        push_rsp(bus.div_egr_tid, 32'hE000_0000 | 32'(bus.div_egr_tid), bus.div_egr_tid[0]);
    end
    rhs = bus.rsp_tvalid & bus.rsp_tready;
    if (rhs != '0) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_extra_beat", rhs, 0);
      end else begin
        er = exp_rsp.pop_front();
        chk("rsp_beat", {rhs, bus.rsp_tuser, bus.rsp_tlast, bus.rsp_tdata}, er);
      end
    end
    if (bus.div_ing_tvalid && bus.div_ing_tready) void'(ing_q.pop_front());
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_egr.size() != 0 || exp_rsp.size() != 0 || ing_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_left", exp_egr.size() + exp_rsp.size() + ing_q.size(), 0);
  endtask

  initial begin
    bus.req_tvalid = '0;
    bus.req_tdata = '0;
    bus.req_tlast = '0;
    bus.rsp_tready = '1;
    bus.div_egr_tready = 1'b1;
    bus.div_ing_tvalid = 1'b0;
    bus.div_ing_tdata = '0;
    bus.div_ing_tlast = 1'b0;
    bus.div_ing_tid = '0;
    bus.div_ing_tuser = 1'b0;

    // Reset: response path stays live, all control outputs quiet.
    push_rsp(3'd1, 32'hAAAA_0001, 1'b0);
    tick();
    chk("rst_rsp_follow", bus.rsp_tvalid, 4'b0010);
    tick();
    chk("rst_req_tready", bus.req_tready, 0);
    chk("rst_egr_tvalid", bus.div_egr_tvalid, 0);
    chk("rst_egr_tid", bus.div_egr_tid, 0);
    chk("rst_pending", sr_pending, 0);
    chk("rst_bad_tid", sr_bad_tid, 0);
    rst_nx = 1'b0;

    // Single requester, one-cycle arbitration latency.
    push_pkt(2, 32'h0001_0000, 32'h0000_0800, 2);
    tick();
    chk("single_c0_vld", bus.div_egr_tvalid, 0);
    tick();
    chk("single_c1_vld_tid", {bus.div_egr_tvalid, bus.div_egr_tid}, {1'b1, 3'd2});
    chk("single_c1_rdy", bus.req_tready, 4'b0100);
    tick();
    tick();
    chk("single_pending", sr_pending, 4'b0100);
    push_rsp(3'd2, 32'h0000_0020, 1'b1);
    tick();
    chk("single_rsp_only2", bus.rsp_tvalid, 4'b0100);
    tick();
    chk("single_pending_clr", sr_pending, 0);

    // Fairness with immediate responses; pointer sits at 3 after the single packet.
    auto_rsp = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++)
        push_pkt(i, {8'hD0, 8'(i), 8'(p), 8'h00}, {8'hD1, 8'(i), 8'(p), 8'h01}, 0);
      for (int k = 0; k < N; k++) begin
        int r;
        r = (3 + k) % N;
        exp_beat(r, 1'b0, {8'hD0, 8'(r), 8'(p), 8'h00});
        exp_beat(r, 1'b1, {8'hD1, 8'(r), 8'(p), 8'h01});
      end
    end
    drain(80);
    auto_rsp = 1'b0;
    tick();
    chk("fair_pending_clr", sr_pending, 0);

    // Pending block: req 1 resubmits before its quotient returns.
    push_pkt(1, 32'hB1A0_0000, 32'hB1A0_0001, 2);
    drain(20);
    push_pkt(1, 32'hB1B0_0000, 32'hB1B0_0001, 0);
    push_pkt(3, 32'hB3C0_0000, 32'hB3C0_0001, 2);
    drain(20);
    tick();
    tick();
    tick();
    chk("blk_no_grant", bus.div_egr_tvalid, 0);
    chk("blk_pending", sr_pending, 4'b1010);
    exp_beat(1, 1'b0, 32'hB1B0_0000);
    exp_beat(1, 1'b1, 32'hB1B0_0001);
    push_rsp(3'd1, 32'h0000_1111, 1'b0);
    tick();
    chk("blk_rsp_cycle_vld", bus.div_egr_tvalid, 0);
    tick();
    chk("blk_grant_cycle_vld", bus.div_egr_tvalid, 0);
    chk("blk_grant_cycle_pend", sr_pending, 4'b1000);
    tick();
    chk("blk_fwd_vld_tid", {bus.div_egr_tvalid, bus.div_egr_tid}, {1'b1, 3'd1});
    drain(20);
    push_rsp(3'd3, 32'h0000_3333, 1'b1);
    push_rsp(3'd1, 32'h0000_1112, 1'b0);
    drain(20);
    tick();
    chk("blk_pending_clr", sr_pending, 0);

    // Egress backpressure mid-packet, then response backpressure on requester 0.
    push_pkt(0, 32'h0BB0_0000, 32'h0BB0_0001, 2);
    tick();
    tick();
    chk("bp_first_beat", bus.div_egr_tvalid, 1);
    egr_rdy_nx = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold", {bus.div_egr_tvalid, bus.div_egr_tlast, bus.div_egr_tid, bus.div_egr_tdata},
          {1'b1, 1'b1, 3'd0, 32'h0BB0_0001});
      chk("bp_req_tready", bus.req_tready, 0);
    end
    egr_rdy_nx = 1'b1;
    tick();
    tick();
    chk("bp_pending", sr_pending, 4'b0001);
    rsp_rdy_nx = 4'b1110;
    push_rsp(3'd0, 32'h0000_0B0B, 1'b1);
    tick();
    chk("rsp_bp_ready", bus.div_ing_tready, 0);
    chk("rsp_bp_valid", bus.rsp_tvalid, 4'b0001);
    tick();
    chk("rsp_bp_ready2", bus.div_ing_tready, 0);
    rsp_rdy_nx = '1;
    drain(10);
    tick();
    chk("bp_pending_clr", sr_pending, 0);

    // Out-of-range tid is swallowed and flagged for one cycle.
    push_pkt(2, 32'h0BAD_0000, 32'h0BAD_0001, 2);
    drain(20);
    tick();
    chk("bad_pre_pending", sr_pending, 4'b0100);
    push_rsp(3'd5, 32'h0000_0555, 1'b0);
    tick();
    chk("bad_no_rsp_vld", bus.rsp_tvalid, 0);
    chk("bad_ing_tready", bus.div_ing_tready, 1);
    chk("bad_flag_early", sr_bad_tid, 0);
    tick();
    chk("bad_flag", sr_bad_tid, 1);
    chk("bad_pending_kept", sr_pending, 4'b0100);
    tick();
    chk("bad_flag_pulse", sr_bad_tid, 0);
    push_rsp(3'd2, 32'h0000_0222, 1'b0);
    drain(10);

    // Reset after the dividend beat of a packet.
    push_pkt(1, 32'h0CC1_0000, 32'h0CC1_0001, 2);
    drain(20);
    tick();
    chk("rm_pre_pending", sr_pending, 4'b0010);
    push_pkt(2, 32'h0CC2_0000, 32'h0CC2_0001, 1);
    tick();
    tick();
    rst_nx = 1'b1;
    egr_rdy_nx = 1'b0;
    tick();
    src_q[2].delete();
    rst_nx = 1'b0;
    egr_rdy_nx = 1'b1;
    tick();
    chk("rm_state", dut.state_q, ARB_IDLE_E);
    chk("rm_egr_tvalid", bus.div_egr_tvalid, 0);
    chk("rm_req_tready", bus.req_tready, 0);
    chk("rm_pending", sr_pending, 0);
    chk("rm_rr_ptr", dut.rr_ptr, 0);
    push_pkt(3, 32'h0DD3_0000, 32'h0DD3_0001, 0);
    push_pkt(0, 32'h0DD0_0000, 32'h0DD0_0001, 2);
    exp_beat(3, 1'b0, 32'h0DD3_0000);
    exp_beat(3, 1'b1, 32'h0DD3_0001);
    drain(20);

    chk("end_exp_egr_empty", exp_egr.size(), 0);
    chk("end_exp_rsp_empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/osc_div_arbiter.md
# osc_div_arbiter

Shares one long-division core between `NR_OF_REQUESTERS_P` oscillator cores. Each core issues a two-beat AXI-stream packet: dividend, then divisor with `tlast`. The arbiter grants requesters round-robin and forwards the whole packet with `tid` set to the requester index. It routes each quotient back to the requester named by the returning `tid`, and allows at most one outstanding division per requester.

## Interface
Parameters:
- `NR_OF_REQUESTERS_P`, -1: number of oscillator cores, at least 2.
- `AXI_DATA_WIDTH_P`, -1: divider data width.
- `AXI_ID_WIDTH_P`, -1: divider `tid` width; must satisfy 2^`AXI_ID_WIDTH_P` ≥ `NR_OF_REQUESTERS_P`.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
  - `clk`, in, 1: system clock.
  - `rst`, in, 1: synchronous reset, active-high.
- Requester side, packed arrays indexed by requester:
  - `req_tvalid`, in, N: request beat valid.
  - `req_tready`, out, N: request beat ready.
  - `req_tdata`, in, N×DW: request data.
  - `req_tlast`, in, N: last beat (divisor).
  - `rsp_tvalid`, out, N: response valid.
  - `rsp_tready`, in, N: response ready.
  - `rsp_tdata`, out, DW: quotient, shared by all requesters.
  - `rsp_tlast`, out, 1: response last.
  - `rsp_tuser`, out, 1: overflow flag.
- Divider side:
  - `div_egr_tvalid`, out, 1.
  - `div_egr_tready`, in, 1.
  - `div_egr_tdata`, out, DW.
  - `div_egr_tlast`, out, 1.
  - `div_egr_tid`, out, IW.
  - `div_ing_tvalid`, in, 1.
  - `div_ing_tready`, out, 1.
  - `div_ing_tdata`, in, DW.
  - `div_ing_tlast`, in, 1.
  - `div_ing_tid`, in, IW.
  - `div_ing_tuser`, in, 1: overflow.
- Status:
  - `sr_pending`, out, N: requester has an outstanding division.
  - `sr_bad_tid`, out, 1: pulses for one cycle when a response with `tid` ≥ N is dropped.

## Operation
Egress FSM states: `ARB_IDLE_E`, `ARB_FORWARD_E`.
- **`ARB_IDLE_E`:**
  - A requester is eligible when `req_tvalid[i]` is high and `sr_pending[i]` is low.
  - Search starts at `rr_ptr` and wraps modulo N; the first eligible requester wins.
  - The winner index is registered into `grant_id`, then go to `ARB_FORWARD_E`.
  - `rr_ptr` is set to winner+1, wrapping to 0 after N-1.
  - With no eligible requester, stay in this state.
  - All `req_tready` are low in this state.
- **`ARB_FORWARD_E`:** combinational pass-through for requester g = `grant_id`.
  - `div_egr_tvalid` = `req_tvalid[g]`.
  - `div_egr_tdata` = `req_tdata[g]`.
  - `div_egr_tlast` = `req_tlast[g]`.
  - `div_egr_tid` = g, zero-extended.
  - `req_tready[g]` = `div_egr_tready`; every other `req_tready` is 0.
  - On a `tlast` beat handshake: set `sr_pending[g]` and return to `ARB_IDLE_E`.
  - Packets of any length are forwarded intact; the grant is held until `tlast`.
- **Ingress demux** (combinational, independent of the FSM):
  - For t = `div_ing_tid` < N: `rsp_tvalid[t]` = `div_ing_tvalid` and `div_ing_tready` = `rsp_tready[t]`.
  - `rsp_tdata`, `rsp_tlast` and `rsp_tuser` are shared, driven from `div_ing_*`.
  - On a `tlast` handshake, clear `sr_pending[t]`.
  - For `tid` ≥ N: `div_ing_tready` = 1, no `rsp_tvalid` is raised, and `sr_bad_tid` pulses the next cycle.
- **Simultaneous set and clear:** `sr_pending` set for g and cleared for t in the same cycle apply independently. g = t cannot occur, because a pending requester is never granted.

## Timing
- Reset values:
  - state `ARB_IDLE_E`, `rr_ptr` 0, `grant_id` 0.
  - `sr_pending` all 0, `sr_bad_tid` 0.
  - all `req_tready` 0, `div_egr_tvalid` 0, `div_egr_tid` 0.
  - `rsp_tvalid` follows `div_ing_tvalid` combinationally, including during reset.
- Arbitration latency: request valid in cycle 0 (state IDLE) → `div_egr_tvalid` high in cycle 1.
- Packet overhead: one idle bubble per packet. A 2-beat packet with `div_egr_tready` held high occupies cycles 1–2, and the next grant forwards from cycle 4.
- AXI rules: `div_egr_tvalid` never drops before its handshake unless the requester violates AXI. Backpressure from `div_egr_tready` and `rsp_tready` propagates with zero cycles of latency.
- Reset mid-packet: in the cycle after `rst`, state is IDLE and all valids and readies are low. The divider shares `rst`, so a partially sent packet is discarded on both sides.

## Structure
- Shared package `oscillator_types_pkg` holds `osc_arb_state_t` (`ARB_IDLE_E`, `ARB_FORWARD_E`).
- Natural sub-module: `rr_arbiter` — N-way round-robin priority encoder.
  - Inputs: `eligible[N]`, `rr_ptr`.
  - Outputs: `winner_id`, `winner_valid`.
  - Purely combinational.
- The top holds the FSM, the `grant_id` and `rr_ptr` registers, `sr_pending`, and the ingress demux.

## Test plan
- **Single requester:** N=4; req 2 sends dividend 0x0001_0000, divisor 0x0000_0800 with tready high → beats appear on `div_egr` in cycles 1–2 with `tid`=2, and `sr_pending` = 4'b0100. A response with `tid`=2 → only `rsp_tvalid[2]` rises; `sr_pending` then reads 0.
- **Fairness:** all 4 requesters valid continuously, responses returned immediately → grant order 0,1,2,3,0,…; no requester waits for more than 3 foreign packets.
- **Pending block:** req 1 sends again before its response returns → req 1 is not granted until the cycle after its response handshake; meanwhile req 3 is granted.
- **Backpressure:** `div_egr_tready` low for 5 cycles mid-packet → grant held and data stable; `req_tready` low on all requesters. `rsp_tready[0]` low → `div_ing_tready` low while `tid`=0.
- **Bad tid:** response with `tid`=5 when N=4 → accepted, no `rsp_tvalid`, `sr_bad_tid` high for one cycle, `sr_pending` unchanged.
- **Reset mid-packet:** `rst` asserted after the dividend beat → next cycle state IDLE, `div_egr_tvalid` 0, `sr_pending` 0, `rr_ptr` 0.
